vga_timing_gen: RTL and testbench

Parametrised VGA/video timing generator, the successor to the fixed 640x480 sync generator. It adds:
- Arbitrary resolution and counter widths.
- Selectable sync polarity.
- A pixel-clock enable, so one fast system clock can drive lower pixel rates.
- Line-start and frame-start strobes.
- A configurable output delay that aligns the sync signals with downstream pixel pipelines.

It sits between the system clock domain and the pattern/framebuffer pixel pipeline that drives the VGA pins.

---
 rtl/vga_timing_pkg.sv | 50 +++++
 rtl/vga_delay_line.sv | 51 +++++
 rtl/vga_timing_gen.sv | 235 +++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared constants and helpers for the VGA timing generator:
//     - sync polarity encodings (SYNC_ACTIVE_HIGH / SYNC_ACTIVE_LOW)
//     - standard timing sets for 640x480@60 and 800x600@60
//     - vga_clog2(): constant-function ceil(log2) used to size the counters
//   No ports (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Sync polarity encodings, used directly as the level of an asserted sync.
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs.
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;
  localparam bit VGA640_H_POL    = SYNC_ACTIVE_LOW;
  localparam bit VGA640_V_POL    = SYNC_ACTIVE_LOW;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs.
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FRONT  = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BACK   = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FRONT  = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BACK   = 23;
  localparam bit SVGA800_H_POL    = SYNC_ACTIVE_HIGH;
  localparam bit SVGA800_V_POL    = SYNC_ACTIVE_HIGH;

  // Largest supported extra output delay.
  localparam int MAX_OUT_DELAY = 4;

  // ceil(log2(value)); usable in parameter/localparam expressions.
  function automatic int vga_clog2(input int value);
    int bits;
    bits = 0;
    while ((64'd1 << bits) < 64'(value)) bits++;
    return bits;
  endfunction

endpackage : vga_timing_pkg

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
//   Parametrised WIDTH x DEPTH shift register with clock enable and a
//   synchronous reset that loads RESET_VAL into every stage.
//   DEPTH = 0 gives a combinational pass-through.
//
// Ports
//   i_clk    system clock
//   i_reset  synchronous active-high reset, overrides i_en
//   i_en     shift enable
//   i_data   word entering the line
//   o_data   word leaving the line (i_data delayed by DEPTH enabled cycles)
// -----------------------------------------------------------------------------
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Clock/reset/enable are intentionally unused in the pass-through.
      logic w_unused;
      assign w_unused = &{1'b0, i_clk, i_reset, i_en};
      assign o_data   = i_data;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // NOTE: every stage is reset, not just the last one; the line is a
      // handful of flops and a partially reset line would leak stale sync
      // levels to the pins for DEPTH enabled cycles after reset.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
        end else if (i_en) begin
          r_stage[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule : vga_delay_line

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised video timing generator. A horizontal/vertical counter pair
//   advances on i_pixelEn; a registered decode stage turns the counter values
//   into sync/active/coordinate/strobe signals, which then pass through an
//   OUT_DELAY-stage delay line so they can be aligned with a downstream pixel
//   pipeline. Region order is active, front porch, sync, back porch.
//
//   Optional feature: define VGA_TIMING_FRAME_CNT_EN to build the frame
//   counter behind o_frameCnt; otherwise o_frameCnt is tied to 0.
//
// Ports
//   i_clk          system clock
//   i_reset        synchronous active-high reset
//   i_pixelEn      pixel-rate enable
//   o_hs / o_vs    horizontal / vertical sync, polarity from *_SYNC_POL
//   o_activeArea   pixel inside H_ACTIVE x V_ACTIVE
//   o_px / o_py    active coordinates, 0 outside the active area
//   o_lineStart    one-clock strobe with the first pixel of every line
//   o_frameStart   one-clock strobe with pixel (0,0)
//   o_frameCnt     completed frames, modulo 2^FRAME_CNT_W
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = VGA640_H_ACTIVE,
  parameter int H_FRONT     = VGA640_H_FRONT,
  parameter int H_SYNC      = VGA640_H_SYNC,
  parameter int H_BACK      = VGA640_H_BACK,
  parameter int V_ACTIVE    = VGA640_V_ACTIVE,
  parameter int V_FRONT     = VGA640_V_FRONT,
  parameter int V_SYNC      = VGA640_V_SYNC,
  parameter int V_BACK      = VGA640_V_BACK,
  parameter bit H_SYNC_POL  = SYNC_ACTIVE_LOW,
  parameter bit V_SYNC_POL  = SYNC_ACTIVE_LOW,
  parameter int PX_W        = 10,
  parameter int PY_W        = 10,
  parameter int OUT_DELAY   = 0,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_pixelEn,
  output logic                   o_hs,
  output logic                   o_vs,
  output logic                   o_activeArea,
  output logic [PX_W-1:0]        o_px,
  output logic [PY_W-1:0]        o_py,
  output logic                   o_lineStart,
  output logic                   o_frameStart,
  output logic [FRAME_CNT_W-1:0] o_frameCnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W     = vga_clog2(H_TOTAL);
  localparam int V_W     = vga_clog2(V_TOTAL);

  localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

  // Bundled output word: {hs, vs, active, line_start, frame_start, px, py[, fc]}.
  // hs/vs sit at the top so the idle word is easy to build.
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam int WORD_W = 5 + PX_W + PY_W + FRAME_CNT_W;
`else
  localparam int WORD_W = 5 + PX_W + PY_W;
`endif
  localparam logic [WORD_W-1:0] IDLE_WORD = {~H_SYNC_POL, ~V_SYNC_POL, {(WORD_W-2){1'b0}}};

  // ---------------------------------------------------------------------------
  // Parameter sanity
  // ---------------------------------------------------------------------------
  generate
    if (PX_W < $clog2(H_ACTIVE)) begin : g_err_px_w
      $error("vga_timing_gen: PX_W too small for H_ACTIVE");
    end
    if (PY_W < $clog2(V_ACTIVE)) begin : g_err_py_w
      $error("vga_timing_gen: PY_W too small for V_ACTIVE");
    end
    if (OUT_DELAY < 0 || OUT_DELAY > MAX_OUT_DELAY) begin : g_err_delay
      $error("vga_timing_gen: OUT_DELAY must be 0..4");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;
  logic           w_h_last;
  logic           w_v_last;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop in
  // this block samples the pre-edge values; that is what lets vCnt step in
  // the same edge hCnt wraps, with no skew between them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_pixelEn) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Counts at the vCnt wrap; the decode stage samples it together with pixel
  // (0,0), so the new value reaches the pins in step with o_frameStart.
  logic [FRAME_CNT_W-1:0] r_frame_src;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_src <= '0;
    end else if (i_pixelEn && w_h_last && w_v_last) begin
      r_frame_src <= r_frame_src + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Decode (combinational, from the pre-increment counter values)
  // ---------------------------------------------------------------------------
  logic            w_hs;
  logic            w_vs;
  logic            w_active;
  logic            w_line_start;
  logic            w_frame_start;
  logic [PX_W-1:0] w_px;
  logic [PY_W-1:0] w_py;

  // NOTE: every output gets a default at the top of the block so no path
  // leaves a signal unassigned, which is what keeps latches from appearing.
  always_comb begin
    w_hs          = ~H_SYNC_POL;
    w_vs          = ~V_SYNC_POL;
    w_active      = 1'b0;
    w_line_start  = 1'b0;
    w_frame_start = 1'b0;
    w_px          = '0;
    w_py          = '0;

    if (int'(r_h_cnt) >= H_SYNC_START && int'(r_h_cnt) < H_SYNC_END) w_hs = H_SYNC_POL;
    if (int'(r_v_cnt) >= V_SYNC_START && int'(r_v_cnt) < V_SYNC_END) w_vs = V_SYNC_POL;

    if (int'(r_h_cnt) < H_ACTIVE && int'(r_v_cnt) < V_ACTIVE) begin
      w_active = 1'b1;
      w_px     = PX_W'(r_h_cnt);
      w_py     = PY_W'(r_v_cnt);
    end

    if (r_h_cnt == '0) begin
      w_line_start  = 1'b1;
      w_frame_start = (r_v_cnt == '0);
    end
  end

  logic [WORD_W-1:0] w_dec_word;

`ifdef VGA_TIMING_FRAME_CNT_EN
  assign w_dec_word = {w_hs, w_vs, w_active, w_line_start, w_frame_start, w_px, w_py, r_frame_src};
`else
  assign w_dec_word = {w_hs, w_vs, w_active, w_line_start, w_frame_start, w_px, w_py};
`endif

  // ---------------------------------------------------------------------------
  // Decode register (the one mandatory latency stage) and extra delay
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] r_dec_word;
  logic [WORD_W-1:0] w_out_word;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dec_word <= IDLE_WORD;
    end else if (i_pixelEn) begin
      r_dec_word <= w_dec_word;
    end
  end

  vga_delay_line #(
    .WIDTH     (WORD_W),
    .DEPTH     (OUT_DELAY),
    .RESET_VAL (IDLE_WORD)
  ) u_delay (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (i_pixelEn),
    .i_data  (r_dec_word),
    .o_data  (w_out_word)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic w_out_line_start;
  logic w_out_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
  assign {o_hs, o_vs, o_activeArea, w_out_line_start, w_out_frame_start,
          o_px, o_py, o_frameCnt} = w_out_word;
`else
  assign {o_hs, o_vs, o_activeArea, w_out_line_start, w_out_frame_start,
          o_px, o_py} = w_out_word;
  assign o_frameCnt = '0;
`endif

  // The strobe bits in the word are held while the pipeline is stalled, so
  // they are qualified with "the last edge advanced the pipeline" to make
  // them exactly one i_clk wide regardless of the pixel rate.
  logic r_advanced;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_advanced <= 1'b0;
    end else begin
      r_advanced <= i_pixelEn;
    end
  end

  assign o_lineStart  = w_out_line_start  & r_advanced;
  assign o_frameStart = w_out_frame_start & r_advanced;

endmodule : vga_timing_gen

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Drives two vga_timing_gen instances (OUT_DELAY=0 with negative syncs, and
//   OUT_DELAY=3 with active-high hsync) from a shared clock, reset and pixel
//   enable, and compares every output on every clock against a reference
//   model that works from the enabled-pixel index: index -> frame, x, y.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  // Small timing so many frames fit in a short run.
  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 10, VF = 2, VS = 3, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 32
  localparam int VT = VA + VF + VS + VB;   // 18
  localparam int FT = HT * VT;             // 576
  localparam int PXW = 5, PYW = 4, FCW = 2;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_pixelEn = 1'b0;

  logic           hs0, vs0, act0, ls0, fs0;
  logic [PXW-1:0] px0;
  logic [PYW-1:0] py0;
  logic [FCW-1:0] fc0;
  logic           hs3, vs3, act3, ls3, fs3;
  logic [PXW-1:0] px3;
  logic [PYW-1:0] py3;
  logic [FCW-1:0] fc3;

  always #5 i_clk = ~i_clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .PX_W(PXW), .PY_W(PYW), .OUT_DELAY(0), .FRAME_CNT_W(FCW)
  ) u_dut0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_pixelEn(i_pixelEn),
    .o_hs(hs0), .o_vs(vs0), .o_activeArea(act0), .o_px(px0), .o_py(py0),
    .o_lineStart(ls0), .o_frameStart(fs0), .o_frameCnt(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0),
    .PX_W(PXW), .PY_W(PYW), .OUT_DELAY(3), .FRAME_CNT_W(FCW)
  ) u_dut3 (
    .i_clk(i_clk), .i_reset(i_reset), .i_pixelEn(i_pixelEn),
    .o_hs(hs3), .o_vs(vs3), .o_activeArea(act3), .o_px(px3), .o_py(py3),
    .o_lineStart(ls3), .o_frameStart(fs3), .o_frameCnt(fc3)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: enabled edges since the last reset, and whether the most
  // recent edge was an enabled one (strobes are visible only then).
  int en_count = 0;
  bit last_en  = 1'b0;
  int cycle    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  // Word layout: [15]hs [14]vs [13]active [12]line_start [11]frame_start
  //              [10:6]px [5:2]py [1:0]frame_cnt
  function automatic logic [63:0] pack(input logic hs, input logic vs, input logic act,
                                       input logic ls, input logic fs,
                                       input logic [PXW-1:0] px, input logic [PYW-1:0] py,
                                       input logic [FCW-1:0] fc);
    logic [63:0] w;
    w        = '0;
    w[15]    = hs;
    w[14]    = vs;
    w[13]    = act;
    w[12]    = ls;
    w[11]    = fs;
    w[10:6]  = px;
    w[5:2]   = py;
    w[1:0]   = fc;
    return w;
  endfunction

  // Expected output of an instance with extra delay d: it shows the pixel
  // whose index is (enabled edges - 1 - d); before that, the idle levels.
  function automatic logic [63:0] model_word(input int d, input bit hpol, input bit vpol);
    int idx, pos, x, y, f;
    logic hs, vs, act, ls, fs;
    logic [PXW-1:0] px;
    logic [PYW-1:0] py;
    logic [FCW-1:0] fc;
    idx = en_count - 1 - d;
    if (idx < 0) return pack(~hpol, ~vpol, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    f   = idx / FT;
    pos = idx % FT;
    x   = pos % HT;
    y   = pos / HT;
    hs  = (x >= HA + HF && x < HA + HF + HS) ? hpol : ~hpol;
    vs  = (y >= VA + VF && y < VA + VF + VS) ? vpol : ~vpol;
    act = (x < HA) && (y < VA);
    px  = act ? PXW'(x) : '0;
    py  = act ? PYW'(y) : '0;
    ls  = last_en && (x == 0);
    fs  = last_en && (x == 0) && (y == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    fc  = FCW'(f % (1 << FCW));
`else
    fc  = '0;
`endif
    return pack(hs, vs, act, ls, fs, px, py, fc);
  endfunction

  // One clock: apply inputs, advance the model at the edge, compare #1 later.
  task automatic step(input bit en, input bit rst);
    i_pixelEn = en;
    i_reset   = rst;
    @(posedge i_clk);
    cycle++;
    if (rst) begin
      en_count = 0;
      last_en  = 1'b0;
    end else begin
      if (en) en_count++;
      last_en = en;
    end
    #1;
    check("dut0_word", pack(hs0, vs0, act0, ls0, fs0, px0, py0, fc0), model_word(0, 1'b0, 1'b0));
    check("dut3_word", pack(hs3, vs3, act3, ls3, fs3, px3, py3, fc3), model_word(3, 1'b1, 1'b0));
  endtask

  int cnt_hs, cnt_vs, cnt_act, cnt_ls, cnt_fs, cnt_hs3;
  int fs_first, fs_second, px_max, py_max;
  logic [63:0] exp_fc;

  initial begin
    // ---- reset ----
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("reset_hs", {63'b0, hs0}, 64'd1);
    check("reset_hs3_pol", {63'b0, hs3}, 64'd0);
    check("reset_active", {63'b0, act0}, 64'd0);

    // ---- full rate, two frames, per-frame aggregates ----
    cnt_hs = 0; cnt_vs = 0; cnt_act = 0; cnt_ls = 0; cnt_fs = 0; cnt_hs3 = 0;
    px_max = 0; py_max = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      step(1'b1, 1'b0);
      if (i < FT) begin
        cnt_hs  += (hs0 == 1'b0);
        cnt_vs  += (vs0 == 1'b0);
        cnt_act += act0;
        cnt_ls  += ls0;
        cnt_fs  += fs0;
        if (int'(px0) > px_max) px_max = int'(px0);
        if (int'(py0) > py_max) py_max = int'(py0);
      end
      if (i >= 3 && i < FT + 3) cnt_hs3 += (hs3 == 1'b1);
    end
    check("hs_low_clocks_per_frame", 64'(cnt_hs), 64'(HS * VT));
    check("vs_low_clocks_per_frame", 64'(cnt_vs), 64'(VS * HT));
    check("active_clocks_per_frame", 64'(cnt_act), 64'(HA * VA));
    check("line_starts_per_frame", 64'(cnt_ls), 64'(VT));
    check("frame_starts_per_frame", 64'(cnt_fs), 64'd1);
    check("px_max", 64'(px_max), 64'(HA - 1));
    check("py_max", 64'(py_max), 64'(VA - 1));
    check("hs3_high_clocks_per_frame", 64'(cnt_hs3), 64'(HS * VT));

    // ---- enable exactly 1 clock in 4: frame period ----
    step(1'b0, 1'b1);
    fs_first = -1; fs_second = -1;
    for (int i = 0; i < 8 * FT + 8; i++) begin
      step((i % 4) == 0, 1'b0);
      if (fs0) begin
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
    end
    check("frame_period_en_1_in_4", 64'(fs_second - fs_first), 64'(4 * FT));

    // ---- random enable, about 1 in 4, then fully random ----
    for (int i = 0; i < 3 * FT; i++) step($urandom_range(3) == 0, 1'b0);
    for (int i = 0; i < FT; i++) step($urandom_range(1) == 1, 1'b0);

    // ---- reset mid-frame (line 5, pixel 9) for 2 clocks ----
    step(1'b0, 1'b1);
    for (int i = 0; i < 5 * HT + 9; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("midreset_active", {63'b0, act0}, 64'd0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("postreset_idle_px", 64'(px0), 64'd0);
    step(1'b1, 1'b0);
    check("postreset_frame_start", {63'b0, fs0}, 64'd1);
    check("postreset_active", {63'b0, act0}, 64'd1);
    for (int i = 0; i < 2 * FT; i++) step($urandom_range(2) != 0, 1'b0);

    // ---- five complete frames then the frame counter ----
    step(1'b1, 1'b1);
    for (int i = 0; i < 5 * FT + 1; i++) step(1'b1, 1'b0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    exp_fc = 64'd1;
`else
    exp_fc = 64'd0;
`endif
    check("frame_cnt_after_5_frames", 64'(fc0), exp_fc);
    check("frame_start_frame_5", {63'b0, fs0}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_vga_timing_gen
